clkdiv_ctrl: RTL
================

Name: clkdiv_ctrl

Overview:
- Run-time programmable controller for the board's divided timebase.
- Replaces a free-running, fixed-ratio divider counter with an FSM that can be configured, started, paused and stopped.
- Produces a one-cycle `tick` enable and a 50%-duty square output `sq_out` for downstream slow logic (display scan, blink, debounce sampling).
- Sits between the top-level control/switch decode and the slow-rate consumers.

Parameters:
- WIDTH, 26, width of divide register and internal counter.
- DEFAULT_DIV, 26'd25_000_000, divide value loaded at reset (tick every DEFAULT_DIV cycles).
- CNT_W, 8, width of `tick_count`.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration word present.
- cfg_ready  out  1  controller accepts configuration (high only in IDLE).
- cfg_div  in  WIDTH  new divide value.
- cfg_oneshot  in  1  1 = single tick then stop; 0 = periodic.
- start  in  1  start request (level sampled).
- stop  in  1  stop request (level sampled).
- hold  in  1  pause while high.
- tick  out  1  one-cycle pulse per elapsed period.
- sq_out  out  1  toggles on every tick; period = 2*div.
- busy  out  1  high in RUN.
- tick_count  out  CNT_W  number of ticks since last start, wraps.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values:
  - state = IDLE, div_r = DEFAULT_DIV, oneshot_r = 0, cnt = 0.
  - tick = 0, sq_out = 0, tick_count = 0.
  - busy = 0, cfg_ready = 1.
- States: IDLE, RUN. busy = (state == RUN); cfg_ready = (state == IDLE). Both are combinational from state.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. div_r and oneshot_r update on that edge.
  - cfg_div == 0 is stored as 1.
  - In RUN, cfg_ready = 0 and the config is not taken. The source must hold cfg_valid.
- IDLE:
  - cnt = 0, tick = 0.
  - On start (and not stop): go to RUN; cnt <= 0; tick_count <= 0; sq_out <= 0.
  - If cfg transfer and start occur in the same cycle, the new config applies to that run.
- RUN, each edge, in priority order:
  1. stop = 1: go to IDLE; cnt <= 0; tick <= 0; sq_out <= 0; no tick emitted that cycle.
  2. hold = 1: cnt, sq_out, tick_count frozen; tick <= 0.
  3. cnt == div_r-1: cnt <= 0; tick <= 1; sq_out <= ~sq_out; tick_count <= tick_count+1 (wraps to 0 after all-ones). If oneshot_r, state <= IDLE on the same edge.
  4. Otherwise: cnt <= cnt+1; tick <= 0.
- Latency: with start sampled at edge E0, the first tick is high in the cycle after edge E0+div_r. Subsequent ticks are every div_r cycles.
- div_r = 1: tick is continuously high in periodic mode, and sq_out toggles every cycle.
- start while in RUN is ignored (no restart).
- tick is registered and never high in IDLE except the cycle immediately following the final one-shot edge.
- Reset asserted mid-run returns every output to its reset value on the next edge, regardless of other inputs.

Optional Feature:
- Macro: CLKDIV_CTRL_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE (default 8) and a prescale counter.
  - cnt advances only on edges where the prescaler is at PRESCALE-1; the prescaler wraps at that point.
  - Tick period becomes div_r*PRESCALE cycles.
  - The prescaler is cleared on start, stop and reset, and frozen by hold.
- Undefined: cnt advances every RUN cycle as above; no prescaler logic is present.

Test Plan:
- Reset, then check outputs: tick = 0, sq_out = 0, busy = 0, cfg_ready = 1, tick_count = 0. Start with no config, DEFAULT_DIV overridden to 4 → tick pulses every 4 cycles, first in the cycle after E0+4, and sq_out period is 8 cycles.
- Config: cfg_div = 3, cfg_oneshot = 1, then start → exactly one tick 3 cycles after entering RUN. busy falls with that tick, tick_count = 1, and no further ticks occur.
- Periodic run with div = 5: assert hold for 7 cycles mid-period → no tick during hold. The tick following hold arrives exactly at the remaining-count offset, and tick_count is unaffected.
- Stop asserted on the same cycle cnt == div_r-1 → no tick, state returns to IDLE, sq_out = 0. cfg_valid held during RUN is accepted the first cycle after stop (cfg_ready = 1).
- cfg_div = 0 → behaves as div 1, giving continuous tick. Run 260 ticks with CNT_W = 8 → tick_count wraps from 255 to 0 and reads 4.
- Assert reset mid-run with div = 10 → all outputs at reset values the next cycle, and div_r = DEFAULT_DIV. With CLKDIV_CTRL_PRESCALE_EN, div = 2 and PRESCALE = 8 → tick every 16 cycles.

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: programmable timebase divider with start/stop/hold, one-shot mode and tick counter.
// Define CLKDIV_CTRL_PRESCALE_EN to add a PRESCALE-cycle prescaler in front of the divide counter.
module clkdiv_ctrl #(
    parameter int WIDTH = 26,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = 26'd25_000_000,
    parameter int CNT_W = 8
`ifdef CLKDIV_CTRL_PRESCALE_EN
    , parameter int PRESCALE = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    output logic             tick,
    output logic             sq_out,
    output logic             busy,
    output logic [CNT_W-1:0] tick_count
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [WIDTH-1:0] div_r, cnt;
    logic oneshot_r;
    logic step;
    assign busy = state == RUN;
    assign cfg_ready = state == IDLE;
`ifdef CLKDIV_CTRL_PRESCALE_EN
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre;
    assign step = pre == PW'(PRESCALE - 1);
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start && !stop) || (state == RUN && stop))
            pre <= '0;
        else if (state == RUN && !hold)
            pre <= step ? '0 : pre + 1'b1;
    end
`else
    assign step = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_r      <= DEFAULT_DIV;
            oneshot_r  <= 1'b0;
            cnt        <= '0;
            tick       <= 1'b0;
            sq_out     <= 1'b0;
            tick_count <= '0;
        end else if (state == IDLE) begin
            tick <= 1'b0;
            cnt  <= '0;
            if (cfg_valid) begin
                div_r     <= cfg_div == '0 ? WIDTH'(1) : cfg_div;
                oneshot_r <= cfg_oneshot;
            end
            if (start && !stop) begin
                state      <= RUN;
                tick_count <= '0;
                sq_out     <= 1'b0;
            end
        end else if (stop) begin
            state  <= IDLE;
            cnt    <= '0;
            tick   <= 1'b0;
            sq_out <= 1'b0;
        end else if (hold || !step) begin
            tick <= 1'b0;
        end else if (cnt == div_r - 1'b1) begin
            cnt        <= '0;
            tick       <= 1'b1;
            sq_out     <= ~sq_out;
            tick_count <= tick_count + 1'b1;
            if (oneshot_r)
                state <= IDLE;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end
endmodule
